prog_mem: RTL
=============

# prog_mem

Single-port program memory with a word-serial loader, acting as the responder to the fetch stage's `pc` / `instruction` interface. In RUN it returns the instruction at the requested address combinationally, within the same cycle. A valid/ready load channel fills the array from a host or test bench. While the array is empty or being loaded, the block holds the core in reset and returns `HALT`. It sits between the external loader and the core's fetch stage, and owns the core's `rst` line.

## Interface
Parameters:
- `ADDR_W`, default `` `A_SIZE ``: address width; depth is 2**ADDR_W words.
- `DATA_W`, default `` `I_SIZE ``: instruction width.

Ports:
- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  reset, asynchronous, active-low.
- `pc`  in  ADDR_W  fetch address from the fetch stage.
- `instruction`  out  DATA_W  word returned to fetch.
- `core_rst`  out  1  active-low reset to the core; registered.
- `ld_start`  in  1  single-cycle request to begin a load.
- `ld_len`  in  ADDR_W  number of words to load; sampled with `ld_start`.
- `ld_valid`  in  1  loader word valid.
- `ld_data`  in  DATA_W  loader word.
- `ld_par`  in  1  even parity of `ld_data`; used only with `PROG_MEM_PARITY_EN`.
- `ld_ready`  out  1  block accepts a word this cycle; registered.
- `ld_done`  out  1  one-cycle pulse when the load completes.
- `ld_err`  out  1  sticky parity error; tied to 0 without `PROG_MEM_PARITY_EN`.

## Operation
- FSM states: IDLE, LOAD, RUN. `rst`=0 forces IDLE asynchronously.
- Reset values:
  - `core_rst`=0, `ld_ready`=0, `ld_done`=0, `ld_err`=0.
  - Write address = 0, remaining count = 0.
  - Array contents are not reset.
- IDLE:
  - `core_rst`=0 and `instruction`=`HALT`.
  - `ld_start` with `ld_len`≠0 → LOAD; write address cleared to 0; count = `ld_len`; `ld_err` cleared.
  - `ld_start` with `ld_len`=0 → RUN and boots the existing contents; no `ld_done` pulse.
- LOAD:
  - `core_rst`=0, `ld_ready`=1, `instruction`=`HALT`.
  - On `ld_valid`&`ld_ready`: write mem[addr]=`ld_data`, increment addr, decrement count.
  - Accepting the last word (count==1) → RUN with a one-cycle `ld_done` pulse.
  - `ld_start` during LOAD is ignored.
- RUN:
  - `core_rst`=1, `ld_ready`=0, and `instruction`=mem[`pc`] combinationally.
  - `ld_start` → LOAD with the same rules as IDLE, except `ld_len`=0 → IDLE.
  - Since `core_rst` is registered, the core is held in reset from the next edge onward.
- Address arithmetic: `ld_len` is at most 2**ADDR_W−1, so the write address never wraps within one load. `pc` always indexes inside the array.
- `ld_valid` while `ld_ready`=0 has no effect; the loader must keep the word stable until it sees `ld_ready`.

## Timing
- Read latency: 0 cycles; `instruction` follows `pc` combinationally. This matches fetch sampling `instruction` in the same cycle it drives `pc`.
- Write: 1 word per cycle at full throughput; the array updates at the accepting edge.
- `ld_ready` rises 1 cycle after the `ld_start` edge and falls on the edge that accepts the last word.
- `ld_done` and `core_rst`=1 are both asserted in the cycle after the last-word edge. Fetch therefore leaves reset with `pc`=0 against the fully written array.
- Reset asserted mid-LOAD:
  - Block returns to IDLE immediately; the partially written array is kept.
  - `core_rst`=0 and `ld_ready`=0 take effect asynchronously.

## Configuration
- Macro: `PROG_MEM_PARITY_EN`.
- Defined:
  - Each accepted word is checked against `ld_par` (even parity over `ld_data`, XOR of all bits == `ld_par`).
  - On mismatch: the word is not written, `ld_err` sets (sticky until the next `ld_start` or `rst`), and the FSM goes to IDLE with no `ld_done`. The core stays in reset.
- Undefined: `ld_par` is ignored, `ld_err` is constant 0, and no check logic is synthesised.

## Test plan
- Reset → `core_rst`=0, `ld_ready`=0, and `instruction`=`HALT` for any `pc`.
- Load 4 words: `ld_start` with `ld_len`=4, then valid every cycle with data 0x1001..0x1004. Required:
  - `ld_ready` high for exactly 4 cycles.
  - `ld_done` pulses once and `core_rst`=1 in the following cycle.
  - `pc`=2 returns 0x1003 in the same cycle.
- Backpressure: `ld_valid` toggled 1,0,0,1,1 with `ld_len`=3 → exactly 3 writes, at addresses 0,1,2, and `ld_done` follows the third accepted word.
- `ld_start` with `ld_len`=0 from IDLE → RUN with no `ld_done`; previous contents are readable. The same in RUN → IDLE with `core_rst`=0.
- `rst` pulsed after 2 of 5 words → IDLE, and `ld_ready` drops asynchronously. Reload with `ld_len`=1 and data 0xBEEF → mem[0]=0xBEEF and mem[1] keeps its old word.
- With `PROG_MEM_PARITY_EN` defined: 2nd word has a wrong `ld_par` → `ld_err`=1, FSM in IDLE, mem[1] unchanged, no `ld_done`. The next `ld_start` clears `ld_err`.

Source files
------------

// File: rtl/prog_mem.sv
// Program memory with a word-serial valid/ready loader. It owns the core reset line and
// returns HALT while empty or loading. Optional load parity check: PROG_MEM_PARITY_EN.

`ifndef A_SIZE
`define A_SIZE 8
`endif
`ifndef I_SIZE
`define I_SIZE 16
`endif
`ifndef HALT
`define HALT 32'hFFFF_FFFF
`endif

module prog_mem #(
  parameter int unsigned ADDR_W = `A_SIZE,
  parameter int unsigned DATA_W = `I_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instruction,
  output logic              core_rst,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_par,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err
);

  localparam logic [DATA_W-1:0] Halt  = DATA_W'(`HALT);
  localparam int unsigned       Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                core_rst_q, ld_ready_q, ld_done_q, ld_done_d;
  logic                err_q, err_d;
  logic                accept, par_ok, mem_we;
  logic [DATA_W-1:0]   mem_q [Depth];

  assign accept = ld_valid & ld_ready_q;

`ifdef PROG_MEM_PARITY_EN
  assign par_ok = ((^ld_data) == ld_par);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  logic unused_par;
  assign unused_par = ld_par;
  assign par_ok     = 1'b1;
  assign err_q      = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    ld_done_d = 1'b0;
    err_d     = err_q;
    mem_we    = 1'b0;
    unique case (state_q)
      StIdle, StRun: begin
        if (ld_start) begin
          err_d = 1'b0;
          if (ld_len != '0) begin
            state_d = StLoad;
            addr_d  = '0;
            cnt_d   = ld_len;
          end else begin
            // A zero-length start toggles between booting and parking the core.
            state_d = (state_q == StIdle) ? StRun : StIdle;
          end
        end
      end
      StLoad: begin
        if (accept) begin
          if (par_ok) begin
            mem_we = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q - ADDR_W'(1);
            if (cnt_q == ADDR_W'(1)) begin
              state_d   = StRun;
              ld_done_d = 1'b1;
            end
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      cnt_q      <= '0;
      core_rst_q <= 1'b0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      core_rst_q <= (state_d == StRun);
      ld_ready_q <= (state_d == StLoad);
      ld_done_q  <= ld_done_d;
    end
  end

  // Array is deliberately not reset so a partial load survives rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= ld_data;
    end
  end

  assign instruction = (state_q == StRun) ? mem_q[pc] : Halt;
  assign core_rst    = core_rst_q;
  assign ld_ready    = ld_ready_q;
  assign ld_done     = ld_done_q;
  assign ld_err      = err_q;

endmodule
